mem_access_ctrl: RTL and testbench

Memory-stage controller between the execute stage and the data memory (`MEMORY`). It accepts one load/store/pass-through request per handshake and sequences exactly one data-memory access with one-cycle read/write strobes. It captures `valM`, flags out-of-range addresses as `ADR` and presents a registered result to write-back under valid/ready. After an address error it halts further intake until reset, per Y86 exception semantics.

---
 rtl/mem_access_ctrl_pkg.sv | 10 +
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/mem_access_ctrl.sv | 67 ++++++
 tb/tb_mem_access_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: widths, op/stat codes, register ids and FSM states shared by the memory stage
package mem_access_ctrl_pkg;
  localparam int DATA_WID = 32;
  localparam int MAX_ADDR = 10;
  localparam int REG_WID = 4;
  localparam logic [1:0] OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2;
  localparam logic [2:0] STAT_AOK = 3'd1, STAT_HLT = 3'd2, STAT_ADR = 3'd3, STAT_INS = 3'd4;
  localparam logic [REG_WID-1:0] RNONE = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_HALT} state_e;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, data-memory and write-back signals of the memory stage
// master drives requests, memory read data/error and out_ready; slave is the controller.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;
  logic                in_valid, in_ready;
  logic [1:0]          in_op;
  logic [DATA_WID-1:0] in_addr, in_wdata;
  logic [REG_WID-1:0]  in_dstM;
  logic [DATA_WID-1:0] mem_addr, mem_wdata, mem_valM;
  logic                mem_write, mem_read, mem_error;
  logic                out_valid, out_ready;
  logic [DATA_WID-1:0] out_valM;
  logic [REG_WID-1:0]  out_dstM;
  logic [2:0]          out_stat;
  logic                halted;
  modport master(
    output in_valid, in_op, in_addr, in_wdata, in_dstM, mem_valM, mem_error, out_ready,
    input  in_ready, mem_addr, mem_wdata, mem_write, mem_read, out_valid, out_valM, out_dstM, out_stat, halted
  );
  modport slave(
    input  in_valid, in_op, in_addr, in_wdata, in_dstM, mem_valM, mem_error, out_ready,
    output in_ready, mem_addr, mem_wdata, mem_write, mem_read, out_valid, out_valM, out_dstM, out_stat, halted
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller sequencing one data-memory access per request
// CLK/RST_N: clock and async active-low reset; bus: request (in_*), memory (mem_*),
// write-back result (out_*) and the sticky halted flag.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter logic [DATA_WID-1:0] MAX_ADDR = mem_access_ctrl_pkg::MAX_ADDR
) (
  input logic CLK,
  input logic RST_N,
  mem_access_ctrl_if.slave bus
);
  state_e state, state_nx;
  logic [1:0]          op_q;
  logic [DATA_WID-1:0] addr_q, wdata_q, valm_q;
  logic [REG_WID-1:0]  dst_q, out_dst_q;
  logic [2:0]          stat_q;
  logic                halted_q, is_rd, is_wr, err, access;
  assign access = state == S_ACCESS;
  assign is_rd = op_q == OP_READ;
  assign is_wr = op_q == OP_WRITE;
  assign err = (is_rd || is_wr) && (addr_q > MAX_ADDR || bus.mem_error);
  // The latched request only changes on accept, so the memory address holds between accesses.
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.out_valM = valm_q;
  assign bus.out_dstM = out_dst_q;
  assign bus.out_stat = stat_q;
  assign bus.halted = halted_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == S_IDLE   ? (bus.in_valid ? S_ACCESS : S_IDLE) :
               state == S_ACCESS ? S_RESP :
               state == S_RESP   ? (bus.out_ready ? (halted_q ? S_HALT : S_IDLE) : S_RESP) :
                                   S_HALT;
    bus.in_ready = state == S_IDLE;
    bus.out_valid = state == S_RESP;
    bus.mem_read = access && is_rd && !err;
    bus.mem_write = access && is_wr && !err;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      op_q <= OP_NOP;
      addr_q <= '0;
      wdata_q <= '0;
      dst_q <= RNONE;
      valm_q <= '0;
      out_dst_q <= RNONE;
      stat_q <= STAT_AOK;
      halted_q <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.in_valid) begin
        op_q <= bus.in_op;
        addr_q <= bus.in_addr;
        wdata_q <= bus.in_wdata;
        dst_q <= bus.in_dstM;
      end
      if (access) begin
        valm_q <= is_rd && !err ? bus.mem_valM : '0;
        out_dst_q <= is_rd ? dst_q : RNONE;
        stat_q <= err ? STAT_ADR : STAT_AOK;
        halted_q <= halted_q | err;
      end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench with a per-request reference model of the memory stage
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;
  logic CLK = 1'b0, RST_N = 1'b0;
  always #5 CLK = ~CLK;
  mem_access_ctrl_if bus();
  mem_access_ctrl dut(.CLK(CLK), .RST_N(RST_N), .bus(bus));

  logic [31:0] env_mem [0:10];
  logic [31:0] ref_mem [0:10];
  logic force_err = 1'b0;
  assign bus.mem_valM = bus.mem_addr <= 32'd10 ? env_mem[bus.mem_addr[3:0]] : 32'hBAD0_BAD0;
  assign bus.mem_error = force_err;
  always @(posedge CLK) if (bus.mem_write && bus.mem_addr <= 32'd10) env_mem[bus.mem_addr[3:0]] <= bus.mem_wdata;

  typedef struct packed {logic [31:0] valm; logic [3:0] dst; logic [2:0] stat;} exp_t;
  exp_t q[$];
  exp_t e, ea;
  int checks = 0, errors = 0, cyc = 0;
  int resp_cyc, strobe_cyc, err_cyc, last_acc, rdy_mode = 1;
  bit busy, halt_m, mon_en = 0, bb_mode = 0, stall_seen, s_rd, s_wr, a_rd, a_wr, a_er;
  logic [31:0] s_addr, s_wdata, st_valm;
  logic [3:0] st_dst;
  logic [2:0] st_stat;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) begin
    #1;
    bus.out_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom % 2);
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_clear();
    q.delete();
    busy = 0; halt_m = 0; stall_seen = 0;
    err_cyc = 1 << 30; strobe_cyc = -1; resp_cyc = 0; last_acc = -1;
  endfunction

  // Monitor: samples on the falling edge, the following rising edge is where handshakes take effect.
  always @(negedge CLK) if (RST_N && mon_en) begin
    chk("in_ready", 32'(bus.in_ready), 32'(!busy && !halt_m));
    chk("halted", 32'(bus.halted), 32'(cyc >= err_cyc));
    chk("out_valid", 32'(bus.out_valid), 32'(busy && cyc >= resp_cyc));
    chk("mem_read", 32'(bus.mem_read), 32'(cyc == strobe_cyc && s_rd));
    chk("mem_write", 32'(bus.mem_write), 32'(cyc == strobe_cyc && s_wr));
    if (cyc == strobe_cyc && (s_rd || s_wr)) chk("mem_addr", bus.mem_addr, s_addr);
    if (cyc == strobe_cyc && s_wr) chk("mem_wdata", bus.mem_wdata, s_wdata);
    if (bus.out_valid && stall_seen) begin
      chk("stall_valM", bus.out_valM, st_valm);
      chk("stall_dstM", 32'(bus.out_dstM), 32'(st_dst));
      chk("stall_stat", 32'(bus.out_stat), 32'(st_stat));
    end
    stall_seen = bus.out_valid && !bus.out_ready;
    st_valm = bus.out_valM; st_dst = bus.out_dstM; st_stat = bus.out_stat;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("out_valM", bus.out_valM, e.valm);
        chk("out_dstM", 32'(bus.out_dstM), 32'(e.dst));
        chk("out_stat", 32'(bus.out_stat), 32'(e.stat));
        if (e.stat == 3'd3) halt_m = 1;
      end
      busy = 0;
    end
    if (bus.in_valid && bus.in_ready) begin
      a_rd = bus.in_op == 2'd1;
      a_wr = bus.in_op == 2'd2;
      a_er = (a_rd || a_wr) && (bus.in_addr > 32'd10 || force_err);
      ea.valm = a_rd && !a_er ? ref_mem[bus.in_addr[3:0]] : 32'd0;
      ea.dst = a_rd ? bus.in_dstM : 4'hF;
      ea.stat = a_er ? 3'd3 : 3'd1;
      if (a_wr && !a_er) ref_mem[bus.in_addr[3:0]] = bus.in_wdata;
      q.push_back(ea);
      busy = 1;
      strobe_cyc = cyc + 1;
      resp_cyc = cyc + 2;
      s_rd = a_rd && !a_er; s_wr = a_wr && !a_er;
      s_addr = bus.in_addr; s_wdata = bus.in_wdata;
      if (a_er) err_cyc = cyc + 2;
      if (bb_mode && last_acc >= 0) chk("bb_interval", cyc + 1 - last_acc, 32'd3);
      last_acc = cyc + 1;
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic [3:0] dst);
    bit ok = 0;
    bus.in_valid = 1; bus.in_op = op; bus.in_addr = a; bus.in_wdata = d; bus.in_dstM = dst;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge CLK);
      if (bus.in_ready) ok = 1;
    end
    chk("accept", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge CLK);
      #1;
    end
    bus.in_valid = 0; bus.in_op = 2'($urandom); bus.in_addr = $urandom; bus.in_wdata = $urandom;
  endtask

  task automatic try_send(input logic [1:0] op, input logic [31:0] a);
    bus.in_valid = 1; bus.in_op = op; bus.in_addr = a;
    repeat (10) begin
      @(negedge CLK);
      #1;
      chk("halt_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge CLK);
    #1;
    bus.in_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (busy || q.size() != 0); i++) begin
      @(negedge CLK);
      #1;
    end
    chk("drain", 32'(busy) | 32'(q.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 0;
    @(posedge CLK);
    #1;
    RST_N = 0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_op = 0; bus.in_addr = 0; bus.in_wdata = 0; bus.in_dstM = 0;
    for (int i = 0; i <= 10; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_valM", bus.out_valM, 32'd0);
    chk("rst_out_dstM", 32'(bus.out_dstM), 32'hF);
    chk("rst_out_stat", 32'(bus.out_stat), 32'd1);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    mon_en = 1;
    send(2'd2, 32'd5, 32'hDEADBEEF, 4'd2);
    send(2'd1, 32'd5, 32'd0, 4'd7);
    wait_idle();
    send(2'd0, 32'd3, 32'h55, 4'd3);
    send(2'd3, 32'd4, 32'h66, 4'd6);
    wait_idle();
    rdy_mode = 2;
    send(2'd1, 32'd5, 32'd0, 4'd9);
    repeat (7) @(posedge CLK);
    rdy_mode = 1;
    wait_idle();
    bb_mode = 1;
    last_acc = -1;
    for (int a = 0; a <= 10; a++) send(2'd2, 32'(a), $urandom, 4'd0);
    wait_idle();
    last_acc = -1;
    for (int a = 0; a <= 10; a++) send(2'd1, 32'(a), 32'd0, 4'(a));
    wait_idle();
    bb_mode = 0;
    rdy_mode = 0;
    repeat (40) begin
      send(2'($urandom % 4), $urandom % 11, $urandom, 4'($urandom));
      repeat ($urandom % 3) @(posedge CLK);
      #1;
    end
    wait_idle();
    rdy_mode = 1;
    send(2'd1, 32'd11, 32'd0, 4'd4);
    wait_idle();
    chk("adr_halted", 32'(bus.halted), 32'd1);
    try_send(2'd1, 32'd1);
    do_reset();
    send(2'd2, 32'h8000_0005, 32'h1234, 4'd0);
    wait_idle();
    do_reset();
    send(2'd1, 32'd5, 32'd0, 4'd1);
    wait_idle();
    force_err = 1;
    send(2'd1, 32'd2, 32'd0, 4'd6);
    wait_idle();
    force_err = 0;
    try_send(2'd2, 32'd2);
    do_reset();
    send(2'd1, 32'd3, 32'd0, 4'd5);
    #1;
    chk("pre_rst_read", 32'(bus.mem_read), 32'd1);
    RST_N = 0;
    model_clear();
    #1;
    chk("midrst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("midrst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(2'd1, 32'd3, 32'd0, 4'd1);
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
